// File: rtl/cfg_access_arbiter_if.sv
// Purpose: bundles the SPI FIFO read sides, filter read port, coefficient RAM port and status of cfg_access_arbiter.
// Latency: none, signal container only.
// Backpressure: FIFO empty flags stall the arbiter; filt_req delays coefficient writes up to the starvation limit.
interface cfg_access_arbiter_if;
    logic       addr_fifo_empty;
    logic [9:0] addr_fifo_dout;
    logic       addr_fifo_rd_en;
    logic       data_fifo_empty;
    logic [7:0] data_fifo_dout;
    logic       data_fifo_rd_en;
    logic       filt_req;
    logic       filt_sel;
    logic [6:0] filt_addr;
    logic       filt_gnt;
    logic       coef_we;
    logic       coef_sel;
    logic [6:0] coef_addr;
    logic [7:0] coef_wdata;
    logic [7:0] freq_word;
    logic       busy;
    logic [7:0] err_cnt;

    // Arbiter side
    modport master (
        input  addr_fifo_empty, addr_fifo_dout, data_fifo_empty, data_fifo_dout,
        input  filt_req, filt_sel, filt_addr,
        output addr_fifo_rd_en, data_fifo_rd_en, filt_gnt,
        output coef_we, coef_sel, coef_addr, coef_wdata,
        output freq_word, busy, err_cnt
    );

    // FIFO / filter / RAM side
    modport slave (
        output addr_fifo_empty, addr_fifo_dout, data_fifo_empty, data_fifo_dout,
        output filt_req, filt_sel, filt_addr,
        input  addr_fifo_rd_en, data_fifo_rd_en, filt_gnt,
        input  coef_we, coef_sel, coef_addr, coef_wdata,
        input  freq_word, busy, err_cnt
    );
endinterface

// File: rtl/cfg_access_arbiter.sv
// Purpose: pops SPI address/data pairs and writes freq_word or the shared I/Q coefficient RAM; CFG_ACCESS_ERR_CNT_EN adds a drop counter.
// Latency: address pop in cycle 0, data pop in cycle 2, coef_we / freq_word update visible in cycle 4.
// Backpressure: waits on an empty data FIFO up to DATA_TIMEOUT; yields to filter reads up to STARVE_LIMIT cycles.
module cfg_access_arbiter #(
    parameter int STARVE_LIMIT = 15,
    parameter int DATA_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    cfg_access_arbiter_if.master  bus
);

    localparam logic [7:0] ST_LIM = 8'(STARVE_LIMIT);
    localparam logic [7:0] TO_LIM = 8'(DATA_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH_ADDR,
        S_WAIT_DATA,
        S_LATCH_DATA,
        S_ARB,
        S_WRITE
    } state_t;

    state_t     state_q;
    logic [9:0] addr_q;
    logic [7:0] data_q;
    logic [7:0] freq_q;
    logic [7:0] to_cnt_q;
    logic [7:0] wait_cnt_q;
    logic       coef_we_q;

    logic [7:0] to_cnt_d;
    logic [7:0] wait_cnt_d;
    logic       is_freq;
    logic       is_i;
    logic       is_q;
    logic       to_expired;
    logic       bad_addr;

    // Address decode and counter increments. The I window (128..198) and Q window
    // (256..326) both start on a 128-aligned base, so the index is simply addr[6:0]
    // and the bank is addr[8].
    always_comb begin
        is_freq    = (addr_q == 10'd2);
        is_i       = (addr_q[9:7] == 3'b001) && (addr_q[6:0] <= 7'd70);
        is_q       = (addr_q[9:7] == 3'b010) && (addr_q[6:0] <= 7'd70);
        to_cnt_d   = to_cnt_q + 8'd1;
        wait_cnt_d = wait_cnt_q + 8'd1;
        to_expired = (state_q == S_WAIT_DATA) && bus.data_fifo_empty && (to_cnt_d == TO_LIM);
        bad_addr   = (state_q == S_LATCH_DATA) && !(is_freq || is_i || is_q);
    end

    // Transaction sequencer: one address/data pair in flight at a time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            freq_q     <= '0;
            to_cnt_q   <= '0;
            wait_cnt_q <= '0;
            coef_we_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!bus.addr_fifo_empty) state_q <= S_LATCH_ADDR;
                end
                S_LATCH_ADDR: begin
                    addr_q   <= bus.addr_fifo_dout;
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    if (!bus.data_fifo_empty) begin
                        state_q <= S_LATCH_DATA;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                        if (to_expired) state_q <= S_IDLE;
                    end
                end
                S_LATCH_DATA: begin
                    data_q <= bus.data_fifo_dout;
                    if (is_freq) begin
                        freq_q  <= bus.data_fifo_dout;
                        state_q <= S_IDLE;
                    end else if (is_i || is_q) begin
                        wait_cnt_q <= '0;
                        if (!bus.filt_req) begin
                            state_q   <= S_WRITE;
                            coef_we_q <= 1'b1;
                        end else begin
                            state_q <= S_ARB;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ARB: begin
                    if (bus.filt_req) wait_cnt_q <= wait_cnt_d;
                    if (!bus.filt_req || (wait_cnt_d == ST_LIM)) begin
                        state_q   <= S_WRITE;
                        coef_we_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    coef_we_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    coef_we_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CFG_ACCESS_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic       drop;

    assign drop = to_expired | bad_addr;

    // Saturating count of dropped transactions (timeout or unmapped address).
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (drop && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = 8'd0;
`endif

    // FIFO pops are suppressed while reset is held so no entry is lost to a reset edge.
    assign bus.addr_fifo_rd_en = !rst && (state_q == S_IDLE) && !bus.addr_fifo_empty;
    assign bus.data_fifo_rd_en = !rst && (state_q == S_WAIT_DATA) && !bus.data_fifo_empty;

    // The RAM port belongs to the filter except during the single write cycle.
    assign bus.coef_we    = coef_we_q & ~rst;
    assign bus.coef_sel   = coef_we_q ? addr_q[8]   : bus.filt_sel;
    assign bus.coef_addr  = coef_we_q ? addr_q[6:0] : bus.filt_addr;
    assign bus.coef_wdata = data_q;
    assign bus.filt_gnt   = bus.filt_req & (rst | ~coef_we_q);

    assign bus.freq_word  = freq_q;
    assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_cfg_access_arbiter.sv
// Purpose: directed self-checking bench for cfg_access_arbiter covering freq, I/Q writes, starvation, drops and reset.
// Latency: checks each transaction cycle by cycle from the address pop (cycle 0) to the write (cycle 4 or later).
// Backpressure: FIFO empty flags and filt_req are driven directly to exercise waits and the starvation limit.
module tb_cfg_access_arbiter;

    logic clk;
    logic rst;

    cfg_access_arbiter_if bus ();

    cfg_access_arbiter #(
        .STARVE_LIMIT (15),
        .DATA_TIMEOUT (255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CFG_ACCESS_ERR_CNT_EN
    localparam int ERR_ON = 1;
`else
    localparam int ERR_ON = 0;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int exp_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Drives cycles 0..3 of one transaction and leaves the bench sampling cycle 4.
    task automatic front(input logic [9:0] a, input logic [7:0] d, input logic req);
        @(negedge clk);
        bus.addr_fifo_empty = 1'b0;
        bus.data_fifo_empty = 1'b0;
        bus.filt_req        = req;
        #1;
        chk("c0_addr_rd_en", 32'(bus.addr_fifo_rd_en), 32'd1);
        chk("c0_data_rd_en", 32'(bus.data_fifo_rd_en), 32'd0);
        @(negedge clk);
        bus.addr_fifo_empty = 1'b1;
        bus.addr_fifo_dout  = a;
        #1;
        chk("c1_addr_rd_en", 32'(bus.addr_fifo_rd_en), 32'd0);
        chk("c1_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        #1;
        chk("c2_data_rd_en", 32'(bus.data_fifo_rd_en), 32'd1);
        @(negedge clk);
        bus.data_fifo_empty = 1'b1;
        bus.data_fifo_dout  = d;
        #1;
        chk("c3_data_rd_en", 32'(bus.data_fifo_rd_en), 32'd0);
        chk("c3_coef_we", 32'(bus.coef_we), 32'd0);
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset with a pending address and an active filter request
        rst = 1'b1;
        bus.addr_fifo_empty = 1'b0;
        bus.addr_fifo_dout  = 10'd0;
        bus.data_fifo_empty = 1'b1;
        bus.data_fifo_dout  = 8'd0;
        bus.filt_req        = 1'b1;
        bus.filt_sel        = 1'b0;
        bus.filt_addr       = 7'd0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_addr_rd_en", 32'(bus.addr_fifo_rd_en), 32'd0);
        chk("rst_filt_gnt", 32'(bus.filt_gnt), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_coef_we", 32'(bus.coef_we), 32'd0);
        chk("rst_freq", 32'(bus.freq_word), 32'd0);
        chk("rst_err", 32'(bus.err_cnt), 32'd0);
        rst = 1'b0;
        bus.addr_fifo_empty = 1'b1;
        bus.filt_req        = 1'b0;

        // Frequency write: addr 2, data 0x5A
        front(10'd2, 8'h5A, 1'b0);
        chk("freq_word", 32'(bus.freq_word), 32'h5A);
        chk("freq_no_we", 32'(bus.coef_we), 32'd0);
        chk("freq_busy", 32'(bus.busy), 32'd0);
        @(negedge clk); #1;
        chk("freq_no_we_c5", 32'(bus.coef_we), 32'd0);

        // I coefficient write: addr 130 -> index 2, data 0x7F
        front(10'd130, 8'h7F, 1'b0);
        chk("i_we", 32'(bus.coef_we), 32'd1);
        chk("i_sel", 32'(bus.coef_sel), 32'd0);
        chk("i_addr", 32'(bus.coef_addr), 32'd2);
        chk("i_wdata", 32'(bus.coef_wdata), 32'h7F);
        @(negedge clk);
        bus.filt_req  = 1'b1;
        bus.filt_sel  = 1'b1;
        bus.filt_addr = 7'h55;
        #1;
        chk("i_we_c5", 32'(bus.coef_we), 32'd0);
        chk("i_busy_c5", 32'(bus.busy), 32'd0);
        chk("pass_addr", 32'(bus.coef_addr), 32'h55);
        chk("pass_sel", 32'(bus.coef_sel), 32'd1);
        chk("pass_gnt", 32'(bus.filt_gnt), 32'd1);
        bus.filt_sel  = 1'b0;
        bus.filt_addr = 7'd5;

        // Q write under constant filter load: addr 300 -> Q index 44, 15 ARB cycles
        front(10'd300, 8'h11, 1'b1);
        chk("arb_we_c4", 32'(bus.coef_we), 32'd0);
        chk("arb_gnt_c4", 32'(bus.filt_gnt), 32'd1);
        for (int k = 5; k <= 18; k++) begin
            @(negedge clk); #1;
            chk("arb_we", 32'(bus.coef_we), 32'd0);
            chk("arb_gnt", 32'(bus.filt_gnt), 32'd1);
        end
        @(negedge clk); #1;
        chk("q_we", 32'(bus.coef_we), 32'd1);
        chk("q_gnt", 32'(bus.filt_gnt), 32'd0);
        chk("q_sel", 32'(bus.coef_sel), 32'd1);
        chk("q_addr", 32'(bus.coef_addr), 32'd44);
        chk("q_wdata", 32'(bus.coef_wdata), 32'h11);
        @(negedge clk); #1;
        chk("q_we_after", 32'(bus.coef_we), 32'd0);
        chk("q_gnt_after", 32'(bus.filt_gnt), 32'd1);
        chk("q_busy_after", 32'(bus.busy), 32'd0);
        bus.filt_req = 1'b0;

        // Unmapped address 100: dropped, no write
        front(10'd100, 8'h33, 1'b0);
        exp_err += ERR_ON;
        chk("bad100_we", 32'(bus.coef_we), 32'd0);
        chk("bad100_busy", 32'(bus.busy), 32'd0);
        chk("bad100_err", 32'(bus.err_cnt), 32'(exp_err));
        chk("bad100_freq", 32'(bus.freq_word), 32'h5A);

        // Just past the I window: 199 is unmapped
        front(10'd199, 8'h66, 1'b0);
        exp_err += ERR_ON;
        chk("bad199_we", 32'(bus.coef_we), 32'd0);
        chk("bad199_err", 32'(bus.err_cnt), 32'(exp_err));

        // Data timeout: address 129 with empty data FIFO for 255 cycles
        @(negedge clk);
        bus.addr_fifo_empty = 1'b0;
        #1;
        chk("to_addr_rd_en", 32'(bus.addr_fifo_rd_en), 32'd1);
        @(negedge clk);
        bus.addr_fifo_empty = 1'b1;
        bus.addr_fifo_dout  = 10'd129;
        for (int k = 2; k <= 256; k++) begin
            @(negedge clk);
        end
        #1;
        chk("to_busy_c256", 32'(bus.busy), 32'd1);
        chk("to_data_rd_en", 32'(bus.data_fifo_rd_en), 32'd0);
        @(negedge clk); #1;
        exp_err += ERR_ON;
        chk("to_busy_c257", 32'(bus.busy), 32'd0);
        chk("to_err", 32'(bus.err_cnt), 32'(exp_err));
        bus.data_fifo_empty = 1'b0;
        bus.data_fifo_dout  = 8'h00;
        #1;
        chk("late_data_not_popped", 32'(bus.data_fifo_rd_en), 32'd0);
        @(negedge clk); #1;
        chk("late_data_idle", 32'(bus.busy), 32'd0);

        // Late data is taken only by the next address: 131 -> I index 3
        front(10'd131, 8'h44, 1'b0);
        chk("late_we", 32'(bus.coef_we), 32'd1);
        chk("late_addr", 32'(bus.coef_addr), 32'd3);
        chk("late_wdata", 32'(bus.coef_wdata), 32'h44);
        @(negedge clk); #1;

        // Reset while in ARB: addr 140, filter busy
        front(10'd140, 8'h22, 1'b1);
        chk("rarb_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rarb_gnt_in_rst", 32'(bus.filt_gnt), 32'd1);
        @(negedge clk); #1;
        chk("rarb_busy_after", 32'(bus.busy), 32'd0);
        chk("rarb_we_after", 32'(bus.coef_we), 32'd0);
        chk("rarb_freq_after", 32'(bus.freq_word), 32'd0);
        chk("rarb_err_after", 32'(bus.err_cnt), 32'd0);
        rst = 1'b0;
        bus.filt_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("post_rst_we", 32'(bus.coef_we), 32'd0);
            chk("post_rst_busy", 32'(bus.busy), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
